// File: rtl/index_decoder.sv
// Binary-index to one-hot decoder with a one-entry valid/ready output stage,
// an accumulated mask of every index seen, its population count and a full flag.
module index_decoder #(
    parameter int logS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [logS-1:0]      in_idx,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [(2**logS)-1:0] out_onehot,
    output logic                 out_dup,
    input  logic                 out_ready,
    input  logic                 clr_mask,
    output logic [(2**logS)-1:0] mask,
    output logic                 mask_full,
    output logic [logS:0]        count
);

    localparam int unsigned    S     = 2**logS;
    localparam logic [logS:0]  S_CNT = (logS+1)'(S);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [S-1:0] f_onehot(input logic [logS-1:0] idx);
        logic [S-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [S-1:0]    r_onehot;
    logic            r_dup;
    logic [S-1:0]    r_mask;
    logic [logS:0]   r_count;
    logic            r_full;

    logic            w_accept;
    logic [S-1:0]    w_mask_base;
    logic [logS:0]   w_count_base;
    logic            w_dup;
    logic [S-1:0]    w_mask_nxt;
    logic [logS:0]   w_count_nxt;

    assign out_valid  = (r_state == ST_HOLD);
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign out_onehot = r_onehot;
    assign out_dup    = r_dup;
    assign mask       = r_mask;
    assign count      = r_count;
    assign mask_full  = r_full;

    // Output-stage next-state: a new accept always lands in HOLD, so no bubble on replace.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (out_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Mask/count update: a same-cycle clear happens before the accepted bit is set.
    always_comb begin
        w_mask_base  = '0;
        w_count_base = '0;
        w_mask_nxt   = '0;
        w_count_nxt  = '0;
        if (clr_mask) begin
            w_mask_base  = '0;
            w_count_base = '0;
        end else begin
            w_mask_base  = r_mask;
            w_count_base = r_count;
        end
        w_dup = w_mask_base[in_idx];
        if (w_accept) begin
            w_mask_nxt  = w_mask_base | f_onehot(in_idx);
            w_count_nxt = w_count_base + {{logS{1'b0}}, ~w_dup};
        end else begin
            w_mask_nxt  = w_mask_base;
            w_count_nxt = w_count_base;
        end
    end

    // State and data registers; reset drops any held item.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_onehot <= '0;
            r_dup    <= 1'b0;
            r_mask   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == S_CNT);
            if (w_accept) begin
                r_onehot <= f_onehot(in_idx);
                r_dup    <= w_dup;
            end else if (w_state_nxt == ST_EMPTY) begin
                r_onehot <= '0;
                r_dup    <= 1'b0;
            end else begin
                r_onehot <= r_onehot;
                r_dup    <= r_dup;
            end
        end
    end

endmodule

// File: tb/tb_index_decoder.sv
// Directed, table-driven bench for index_decoder (logS = 4, S = 16).
module tb_index_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_idx;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_onehot;
    logic        out_dup;
    logic        out_ready;
    logic        clr_mask;
    logic [15:0] mask;
    logic        mask_full;
    logic [4:0]  count;

    int checks   = 0;
    int failures = 0;

    index_decoder #(.logS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_dup    (out_dup),
        .out_ready  (out_ready),
        .clr_mask   (clr_mask),
        .mask       (mask),
        .mask_full  (mask_full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  idx;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [15:0] e_oh;
        logic        e_dup;
        logic [15:0] e_mask;
        logic [4:0]  e_cnt;
        logic        e_full;
        logic        e_irdy;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [3:0] idx, input logic ordy, input logic clr);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_idx    = idx;
        out_ready = ordy;
        clr_mask  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int step, input logic ov, input logic [15:0] oh, input logic dup,
                           input logic [15:0] m, input logic [4:0] c, input logic f, input logic ir);
        chk("out_valid",  step, {31'd0, out_valid},  {31'd0, ov});
        chk("out_onehot", step, {16'd0, out_onehot}, {16'd0, oh});
        chk("out_dup",    step, {31'd0, out_dup},    {31'd0, dup});
        chk("mask",       step, {16'd0, mask},       {16'd0, m});
        chk("count",      step, {27'd0, count},      {27'd0, c});
        chk("mask_full",  step, {31'd0, mask_full},  {31'd0, f});
        chk("in_ready",   step, {31'd0, in_ready},   {31'd0, ir});
    endtask

    initial begin
        logic [15:0] acc;
        logic [15:0] e_oh;

        rst = 1'b1; in_valid = 1'b0; in_idx = 4'd0; out_ready = 1'b0; clr_mask = 1'b0;

        //            rst   iv    idx    ordy  clr   ov    onehot     dup   mask       cnt    full  irdy
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0020, 5'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 16'h0008, 1'b0, 16'h0008, 5'd1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0008, 5'd1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0088, 5'd2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 16'h0008, 5'd1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0008, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h0200, 5'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0200, 5'd1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0204, 5'd2, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0204, 5'd2, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].idx, vecs[i].ordy, vecs[i].clr);
            chk_all(i, vecs[i].e_ov, vecs[i].e_oh, vecs[i].e_dup, vecs[i].e_mask,
                    vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_irdy);
        end

        // Fill the mask with indices 0..15, then keep accepting while full.
        acc = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
            e_oh = 16'h0001 << i;
            acc  = acc | e_oh;
            chk_all(100 + i, 1'b1, e_oh, 1'b0, acc, 5'(i + 1), (i == 15), 1'b1);
        end
        drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk_all(200, 1'b1, 16'h0200, 1'b1, 16'hFFFF, 5'd16, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_all(201, 1'b1, 16'h0200, 1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_all(202, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/index_decoder.md
INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 The parameter list SHALL be: logS, default 4, index width; S = 2**logS is the one-hot width (local, not overridable).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream offers in_idx this cycle.
REQ-006 in_idx  input  logS  binary index to decode.
REQ-007 in_ready  output  1  block accepts in_idx this cycle.
REQ-008 out_valid  output  1  out_onehot/out_dup hold a decoded item.
REQ-009 out_onehot  output  S  registered one-hot decode of the accepted index.
REQ-010 out_dup  output  1  accepted index was already set in mask at acceptance.
REQ-011 out_ready  input  1  downstream consumes the output item this cycle.
REQ-012 clr_mask  input  1  clear accumulated mask.
REQ-013 mask  output  S  OR of all one-hots accepted since the last reset/clear.
REQ-014 mask_full  output  1  mask is all ones.
REQ-015 count  output  logS+1  number of set bits in mask.

Function
REQ-016 The output stage SHALL be a single register with two states: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally; no combinational path from in_valid to any output.
REQ-018 Accept SHALL occur when in_valid && in_ready; on accept, out_onehot <= (1 << in_idx) and out_valid <= 1 on the next edge (latency 1).
REQ-019 Transitions: EMPTY -> HOLD on accept; HOLD -> EMPTY on out_ready without accept; HOLD -> HOLD on out_ready with accept (new item replaces old, no bubble); HOLD with !out_ready SHALL hold out_onehot/out_dup stable.
REQ-020 out_onehot SHALL have exactly one bit set whenever out_valid=1; value is don't-care-free: all zeros while EMPTY.
REQ-021 On accept, out_dup <= mask[in_idx] evaluated before this cycle's mask update, treating mask as zero if clr_mask is asserted in the same cycle.
REQ-022 On accept without clr_mask, mask <= mask | (1 << in_idx); with clr_mask, mask <= (1 << in_idx) (clear before set).
REQ-023 clr_mask without accept SHALL set mask <= 0; clr_mask SHALL not affect out_valid, out_onehot or out_dup.
REQ-024 count SHALL be registered and equal popcount(mask) in the same cycle mask is observed; it increments by 1 only on a non-duplicate accept, becomes 1 on accept with clr_mask, 0 on clr_mask alone.
REQ-025 mask_full SHALL be 1 exactly when count == S; accepts SHALL continue while full (flagged out_dup=1).
REQ-026 Indices are always in range by construction (S = 2**logS); no error output.

Reset
REQ-027 While rst=1 on an edge: out_valid=0, out_onehot=0, out_dup=0, mask=0, count=0, mask_full=0; in_ready=1 after that edge.
REQ-028 rst SHALL override in_valid and clr_mask in the same cycle; an item held mid-handshake SHALL be dropped.

Verification
REQ-029 Reset, then in_idx=5 accepted with out_ready=1 -> next cycle out_valid=1, out_onehot=16'h0020, out_dup=0, mask=16'h0020, count=1.
REQ-030 Back-to-back accepts 3,3,7 with out_ready=1 -> outputs 16'h0008/dup0, 16'h0008/dup1, 16'h0080/dup0; final mask=16'h0088, count=2.
REQ-031 out_ready=0 for 3 cycles while HOLD with in_valid=1 -> in_ready=0, output held unchanged, mask unchanged; out_ready=1 -> pending index accepted same cycle, new item next cycle.
REQ-032 Accept indices 0..15 in order -> count=16, mask_full=1, mask=16'hFFFF; further accept of 9 -> out_dup=1, count stays 16.
REQ-033 mask=16'h0088, accept idx 3 with clr_mask=1 -> out_dup=0, mask=16'h0008, count=1; clr_mask alone -> mask=0, count=0, out_valid unaffected.
REQ-034 rst asserted while HOLD with out_ready=0 -> next cycle out_valid=0, mask=0, count=0, in_ready=1.
